// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : main_fsm
// Description : Multi-cycle controller FSM; sequences fetch/decode/execute/
//               memory/writeback and drives Moore-style datapath controls.
// Revision    : 1.0 - initial release
// ============================================================================
module main_fsm #(
    parameter bit TRAP_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRWB   = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd14,
        S_SPARE    = 4'd15
    } state_t;

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_rtype = 7'b0110011;
    localparam logic [6:0] c_op_itype = 7'b0010011;
    localparam logic [6:0] c_op_beq   = 7'b1100011;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_jalr  = 7'b1100111;
    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_auipc = 7'b0010111;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       illegal;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;

    // Control word for a state; registered against the next state so the
    // outputs are a clean function of the state register.
    function automatic ctrl_t f_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite   = 1'b1;
                c.pcupdate  = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            S_DECODE: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            S_MEMADR: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            S_MEMREAD:  c.adrsrc = 1'b1;
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECR: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b10;
            end
            S_EXECI: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.aluop   = 2'b10;
            end
            S_ALUWB:    c.regwrite = 1'b1;
            S_JAL: begin
                c.alusrca  = 2'b01;
                c.alusrcb  = 2'b10;
                c.pcupdate = 1'b1;
            end
            S_BEQ: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b01;
                c.branch  = 1'b1;
            end
            S_JALR: begin
                c.alusrca   = 2'b10;
                c.alusrcb   = 2'b01;
                c.resultsrc = 2'b10;
                c.pcupdate  = 1'b1;
            end
            S_JALRWB: begin
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.regwrite  = 1'b1;
            end
            S_LUI: begin
                c.alusrca = 2'b11;
                c.alusrcb = 2'b01;
            end
            S_TRAP:     c.illegal = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_op_load, c_op_store: w_next = S_MEMADR;
                    c_op_rtype:            w_next = S_EXECR;
                    c_op_itype:            w_next = S_EXECI;
                    c_op_beq:              w_next = S_BEQ;
                    c_op_jal:              w_next = S_JAL;
                    c_op_jalr:             w_next = S_JALR;
                    c_op_lui:              w_next = S_LUI;
                    c_op_auipc:            w_next = S_ALUWB;
                    default:               w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = (op == c_op_load) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_BEQ:      w_next = S_FETCH;
            S_JALR:     w_next = S_JALRWB;
            S_JALRWB:   w_next = S_FETCH;
            S_LUI:      w_next = S_ALUWB;
            S_TRAP:     w_next = TRAP_HALT ? S_TRAP : S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= f_ctrl(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_ctrl(w_next);
        end
    end

    // zero only matters in BEQ, where branch is the sole source of a PC load.
    assign pcwrite   = r_ctrl.pcupdate | (r_ctrl.branch & zero);
    assign adrsrc    = r_ctrl.adrsrc;
    assign memwrite  = r_ctrl.memwrite;
    assign irwrite   = r_ctrl.irwrite;
    assign resultsrc = r_ctrl.resultsrc;
    assign alusrca   = r_ctrl.alusrca;
    assign alusrcb   = r_ctrl.alusrcb;
    assign aluop     = r_ctrl.aluop;
    assign regwrite  = r_ctrl.regwrite;
    assign illegal   = r_ctrl.illegal;
    assign state     = r_state;

    a_one_strobe: assert property (@(posedge clk) disable iff (reset)
        $onehot0({r_ctrl.regwrite, r_ctrl.memwrite, r_ctrl.irwrite}));

endmodule
`default_nettype wire

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multi-cycle control FSM. Sits beside the immediate-source decoder in the controller and consumes the same 7-bit opcode from the instruction register.
- Sequences Fetch, Decode, Execute, Memory and Writeback for each instruction.
- Drives the datapath enables and mux selects as Moore outputs.
- ALU function decode (funct3/funct7) is downstream and driven by `aluop`.

Parameters:
- TRAP_HALT, 1, 1: an illegal opcode parks the FSM in TRAP until reset. 0: TRAP returns to FETCH after one cycle.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  opcode from instruction register (instr[6:0])
- zero  in  1  ALU zero flag, used only in BEQ
- pcwrite  out  1  PC load enable: pcupdate | (branch & zero)
- adrsrc  out  1  memory address mux: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write strobe
- irwrite  out  1  instruction register and oldPC load enable
- resultsrc  out  2  result mux: 00 = ALUOut, 01 = mem data, 10 = ALU result
- alusrca  out  2  ALU A mux: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero
- alusrcb  out  2  ALU B mux: 00 = rs2, 01 = imm, 10 = const 4
- aluop  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- regwrite  out  1  register file write enable
- illegal  out  1  high while in TRAP
- state  out  4  current state encoding, for debug and verification

Behaviour:
- State register, 4 bits. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, JALR=11, JALRWB=12, LUI=13, TRAP=14.
- Encoding 15 is unreachable. If ever entered, next state is FETCH.
- Reset: asynchronous, state=FETCH. All outputs are pure combinational functions of state, so while reset is held the outputs equal the FETCH values.
- Outputs not listed for a state are 0. `resultsrc`, `alusrca`, `alusrcb` and `aluop` default to 00.
- State outputs and next state:
  - FETCH: irwrite=1, pcupdate=1, alusrca=00, alusrcb=10, resultsrc=10. Next: DECODE.
  - DECODE: alusrca=01, alusrcb=01 (ALUOut <= oldPC+imm). Next by op:
    - 0000011 (load) or 0100011 (store) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 (AUIPC) -> ALUWB
    - any other opcode -> TRAP
  - MEMADR: alusrca=10, alusrcb=01. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: adrsrc=1. Next: MEMWB.
  - MEMWB: resultsrc=01, regwrite=1. Next: FETCH.
  - MEMWRITE: adrsrc=1, memwrite=1. Next: FETCH.
  - EXECR: alusrca=10, alusrcb=00, aluop=10. Next: ALUWB.
  - EXECI: alusrca=10, alusrcb=01, aluop=10. Next: ALUWB.
  - ALUWB: resultsrc=00, regwrite=1. Next: FETCH.
  - JAL: alusrca=01, alusrcb=10, resultsrc=00, pcupdate=1 (PC <= oldPC+imm, ALUOut <= oldPC+4). Next: ALUWB.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1. Next: FETCH.
  - JALR: alusrca=10, alusrcb=01, resultsrc=10, pcupdate=1. Next: JALRWB.
  - JALRWB: alusrca=01, alusrcb=10, resultsrc=10, regwrite=1. Next: FETCH.
  - LUI: alusrca=11, alusrcb=01. Next: ALUWB.
  - TRAP: illegal=1, all write enables 0. Next: TRAP if TRAP_HALT=1, else FETCH.
- `pcwrite` = pcupdate | (branch & zero). `zero` is ignored outside BEQ.
- `op` is sampled only in DECODE and MEMADR. It is stable because irwrite=1 only in FETCH.
- At most one of regwrite, memwrite, irwrite is high in any state.
- Latency in cycles, including FETCH:
  - load 5
  - store 4
  - R-type, I-type, JAL, JALR 4
  - LUI 4
  - AUIPC 3
  - BEQ 3
- Reset asserted mid-instruction: immediate return to FETCH. No write strobe is asserted after reset is released until a new instruction is decoded.

Test Plan:
- Reset, release, op=0000011 -> states 0,1,2,3,4,0. `memwrite` never 1. `regwrite`=1 only in state 4. `irwrite`=1 only in state 0.
- op=0100011 -> states 0,1,2,5,0. `memwrite`=1 with `adrsrc`=1 in state 5. `regwrite` never 1.
- op=1100011, zero=1 then zero=0 on a repeat -> states 0,1,10,0. `pcwrite`=1 in BEQ only when zero=1. `aluop`=01.
- op=1100111 -> states 0,1,11,12,0. `pcwrite`=1 in state 11. `regwrite`=1 in state 12 with `alusrca`=01, `alusrcb`=10.
- op=0010111 -> states 0,1,7,0 (3 cycles). op=0110111 -> states 0,1,13,7,0 with `alusrca`=11 in state 13.
- op=1111111, TRAP_HALT=1 -> state 14 held, `illegal`=1, no enables asserted. Assert reset mid-state 3 of a load -> state=0 asynchronously, before the next clock edge.
